// File: rtl/shift_reg_pkg.sv
// Shared types for the universal shift register: mode codes and shift direction.
package shift_reg_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    SHR  = 2'b01,
    SHL  = 2'b10,
    LOAD = 2'b11
  } shiftMode_t;

  typedef enum logic {
    DIR_R = 1'b0,
    DIR_L = 1'b1
  } dir_t;

endpackage

// File: rtl/shift_bit_counter.sv
// Word-framing counter: counts same-direction shifts and pulses wordValid
// when WIDTH of them have completed. A direction change starts a new word.
module shift_bit_counter
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     shift,
  input  dir_t                     dir,
  input  logic                     load,
  output logic [$clog2(WIDTH)-1:0] bitCount,
  output logic                     wordValid
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [CntW-1:0] cntQ, cntD;
  dir_t            lastDirQ, lastDirD;
  logic            wordValidQ, wordValidD;

  always_comb begin
    cntD       = cntQ;
    lastDirD   = lastDirQ;
    wordValidD = 1'b0;
    if (load) begin
      cntD = '0;
    end else if (shift) begin
      if (dir != lastDirQ) begin
        // The reversed shift is bit 1 of a fresh word.
        cntD     = CntW'(1);
        lastDirD = dir;
      end else if (cntQ == LastCnt) begin
        cntD       = '0;
        wordValidD = 1'b1;
      end else begin
        cntD = cntQ + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntQ       <= '0;
      lastDirQ   <= DIR_R;
      wordValidQ <= 1'b0;
    end else begin
      cntQ       <= cntD;
      lastDirQ   <= lastDirD;
      wordValidQ <= wordValidD;
    end
  end

  assign bitCount  = cntQ;
  assign wordValid = wordValidQ;

endmodule

// File: rtl/param_shift_register.sv
// Parametrised universal shift register (hold / shift right / shift left / load)
// with word framing. Define SHIFT_REG_ROTATE_EN to make the rotate input effective.
module param_shift_register
  import shift_reg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               mode,
  input  logic                     serialInR,
  input  logic                     serialInL,
  input  logic                     rotate,
  input  logic [WIDTH-1:0]         parallelIn,
  output logic                     serialOut,
  output logic [WIDTH-1:0]         parallelOut,
  output logic [$clog2(WIDTH)-1:0] bitCount,
  output logic                     wordValid
);

  shiftMode_t       modeS;
  logic [WIDTH-1:0] dataQ, dataD;
  logic             serialQ, serialD;
  logic             inR, inL;

  assign modeS = shiftMode_t'(mode);

`ifdef SHIFT_REG_ROTATE_EN
  assign inR = rotate ? dataQ[0] : serialInR;
  assign inL = rotate ? dataQ[WIDTH-1] : serialInL;
`else
  logic rotateUnused;
  assign rotateUnused = rotate;
  assign inR = serialInR;
  assign inL = serialInL;
`endif

  always_comb begin
    dataD   = dataQ;
    serialD = serialQ;
    unique case (modeS)
      HOLD: ;
      SHR: begin
        dataD   = {inR, dataQ[WIDTH-1:1]};
        serialD = dataQ[0];
      end
      SHL: begin
        dataD   = {dataQ[WIDTH-2:0], inL};
        serialD = dataQ[WIDTH-1];
      end
      LOAD: dataD = parallelIn;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataQ   <= '0;
      serialQ <= 1'b0;
    end else begin
      dataQ   <= dataD;
      serialQ <= serialD;
    end
  end

  assign parallelOut = dataQ;
  assign serialOut   = serialQ;

  shift_bit_counter #(
    .WIDTH(WIDTH)
  ) uCounter (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift    ((modeS == SHR) || (modeS == SHL)),
    .dir      ((modeS == SHL) ? DIR_L : DIR_R),
    .load     (modeS == LOAD),
    .bitCount (bitCount),
    .wordValid(wordValid)
  );

endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register: arithmetic reference model checked every cycle,
// plus literal expectations from the directed test plan.
module tb_param_shift_register;
  import shift_reg_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          serialInR = 1'b0;
  logic          serialInL = 1'b0;
  logic          rotate = 1'b0;
  logic [W-1:0]  parallelIn = '0;
  logic          serialOut;
  logic [W-1:0]  parallelOut;
  logic [CW-1:0] bitCount;
  logic          wordValid;

  param_shift_register #(
    .WIDTH(W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .serialInR  (serialInR),
    .serialInL  (serialInL),
    .rotate     (rotate),
    .parallelIn (parallelIn),
    .serialOut  (serialOut),
    .parallelOut(parallelOut),
    .bitCount   (bitCount),
    .wordValid  (wordValid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  // Reference state: value as an integer, shifts counted in the current word.
  longint mVal;
  int     mSo;
  int     mCnt;
  int     mWv;
  int     mLeft;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mVal  = 0;
    mSo   = 0;
    mCnt  = 0;
    mWv   = 0;
    mLeft = 0;
  endfunction

  function automatic void modelEdge(input logic [1:0] m, input bit inR, input bit inL,
                                    input bit rot, input longint pin);
    longint half = longint'(1) << (W - 1);
    longint full = longint'(1) << W;
    int     isLeft;
    int     outBit;
    int     inBit;
    mWv = 0;
    if (m == 2'b01 || m == 2'b10) begin
      isLeft = (m == 2'b10) ? 1 : 0;
      outBit = isLeft ? int'((mVal / half) % 2) : int'(mVal % 2);
      inBit  = isLeft ? int'(inL) : int'(inR);
`ifdef SHIFT_REG_ROTATE_EN
      if (rot) inBit = outBit;
`else
      if (rot) inBit = inBit;
`endif
      mVal = isLeft ? ((mVal * 2) % full) + inBit : (mVal / 2) + inBit * half;
      mSo  = outBit;
      if (isLeft != mLeft) begin
        mLeft = isLeft;
        mCnt  = 1;
      end else if (mCnt + 1 == W) begin
        mCnt = 0;
        mWv  = 1;
      end else begin
        mCnt++;
      end
    end else if (m == 2'b11) begin
      mVal = pin;
      mCnt = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (checkEn) begin
      chk("model parallelOut", longint'(parallelOut), mVal);
      chk("model serialOut", longint'(serialOut), longint'(mSo));
      chk("model bitCount", longint'(bitCount), longint'(mCnt));
      chk("model wordValid", longint'(wordValid), longint'(mWv));
    end
  end

  // Drive one cycle's inputs, let the edge happen, advance the model, return at negedge.
  task automatic step(input logic [1:0] m, input bit inR = 1'b0, input bit inL = 1'b0,
                      input bit rot = 1'b0, input logic [W-1:0] pin = '0);
    mode       = m;
    serialInR  = inR;
    serialInL  = inL;
    rotate     = rot;
    parallelIn = pin;
    @(posedge clk);
    modelEdge(m, inR, inL, rot, longint'(pin));
    @(negedge clk);
  endtask

  initial begin
    bit [7:0] rBits;
    rBits = 8'b0100_1101;  // entry order is bit 0 first: 1,0,1,1,0,0,1,0
    modelReset();
    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    chk("reset parallelOut", longint'(parallelOut), 0);
    chk("reset bitCount", longint'(bitCount), 0);
    chk("reset wordValid", longint'(wordValid), 0);
    rst_n = 1'b1;

    // Eight right shifts complete one word.
    for (int i = 0; i < 8; i++) begin
      step(SHR, rBits[i]);
      if (i < 7) chk("early wordValid", longint'(wordValid), 0);
    end
    chk("word parallelOut", longint'(parallelOut), 64'h4D);
    chk("word wordValid", longint'(wordValid), 1);
    chk("word bitCount", longint'(bitCount), 0);
    step(HOLD);
    chk("pulse one cycle", longint'(wordValid), 0);

    // Load then three left shifts.
    step(LOAD, 1'b0, 1'b0, 1'b0, 8'hA5);
    step(SHL);
    chk("shl serialOut 1", longint'(serialOut), 1);
    step(SHL);
    chk("shl serialOut 2", longint'(serialOut), 0);
    step(SHL);
    chk("shl serialOut 3", longint'(serialOut), 1);
    chk("shl parallelOut", longint'(parallelOut), 64'h28);
    chk("shl bitCount", longint'(bitCount), 3);

    // Direction change restarts the word.
    repeat (5) step(SHR, 1'b1);
    step(SHL, 1'b0, 1'b1);
    chk("reverse bitCount", longint'(bitCount), 1);
    chk("reverse wordValid", longint'(wordValid), 0);
    repeat (7) step(SHL, 1'b0, 1'b0);
    chk("left word wordValid", longint'(wordValid), 1);

    // Load on the would-be completing edge suppresses the word.
    repeat (7) step(SHR, 1'b0);
    step(LOAD, 1'b0, 1'b0, 1'b0, 8'h3C);
    chk("load wordValid", longint'(wordValid), 0);
    chk("load bitCount", longint'(bitCount), 0);
    chk("load parallelOut", longint'(parallelOut), 64'h3C);
    for (int i = 0; i < 4; i++) begin
      // Mode glitches between edges must not matter.
      mode = 2'b11;
      #2;
      mode = 2'b01;
      #1;
      step(HOLD, 1'b1, 1'b1);
    end
    chk("hold parallelOut", longint'(parallelOut), 64'h3C);
    chk("hold bitCount", longint'(bitCount), 0);

    // Asynchronous reset mid-word.
    repeat (4) step(SHR, 1'b1);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    chk("async parallelOut", longint'(parallelOut), 0);
    chk("async serialOut", longint'(serialOut), 0);
    chk("async bitCount", longint'(bitCount), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(SHR, 1'b1);
      if (i == 6) chk("post-reset 7th wordValid", longint'(wordValid), 0);
    end
    chk("post-reset 8th wordValid", longint'(wordValid), 1);

    // Rotate request.
    step(LOAD, 1'b0, 1'b0, 1'b0, 8'h81);
    step(SHR, 1'b0, 1'b0, 1'b1);
`ifdef SHIFT_REG_ROTATE_EN
    chk("rotate right", longint'(parallelOut), 64'hC0);
`else
    chk("rotate ignored", longint'(parallelOut), 64'h40);
`endif
    step(HOLD);

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
